pulse_edge_encoder: RTL and testbench

PULSE_EDGE_ENCODER -- requirements
Module: pulse_edge_encoder

---
 rtl/pulse_pkg.sv | 13 +
 rtl/pulse_sync_filter.sv | 60 ++++++
 rtl/pulse_edge_encoder.sv | 107 ++++++++++
 tb/tb_pulse_edge_encoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse edge encoder and its edge-to-level reconstruction partner.
package pulse_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MIN_WIDTH   = 1;
  localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/pulse_sync_filter.sv
// Synchronizes an asynchronous level and removes excursions shorter than MIN_WIDTH cycles.
// dout changes SYNC_STAGES+MIN_WIDTH-1 edges after the first edge that samples a stable new din.
module pulse_sync_filter
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_WIDTH   = DEF_MIN_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic din,
  output logic dout
);

  localparam logic [7:0] LAST = 8'(MIN_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [7:0]             cnt;
  logic                   level;

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("pulse_sync_filter: SYNC_STAGES must be 2..4");
    end
    if (MIN_WIDTH < 1 || MIN_WIDTH > 255) begin : g_bad_width
      $error("pulse_sync_filter: MIN_WIDTH must be 1..255");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

  assign synced = sync[SYNC_STAGES-1];

  // The counter tracks how long the synced input has disagreed with the level;
  // the level flips on the edge that would take it to MIN_WIDTH.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (synced == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign dout = level;

endmodule

// File: rtl/pulse_edge_encoder.sv
// Encodes a filtered level into rise/fall strobes and measures each pulse width in clk cycles.
// Strobes appear SYNC_STAGES+MIN_WIDTH cycles after the input change; width saturates with overflow flag.
module pulse_edge_encoder
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_WIDTH   = DEF_MIN_WIDTH,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             pulse_in,
  output logic             rising_edge,
  output logic             falling_edge,
  output logic             active,
  output logic [CNT_W-1:0] width,
  output logic             width_valid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             level;
  logic             rise_evt;
  logic             fall_evt;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  pulse_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_WIDTH   (MIN_WIDTH)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .din   (pulse_in),
    .dout  (level)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (level)  state_nxt = ACTIVE;
      ACTIVE:  if (!level) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    active   = (state == ACTIVE);
    rise_evt = (state == IDLE)   && (state_nxt == ACTIVE);
    fall_evt = (state == ACTIVE) && (state_nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rising_edge  <= 1'b0;
      falling_edge <= 1'b0;
      width_valid  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      rising_edge  <= rise_evt;
      falling_edge <= fall_evt;
      width_valid  <= fall_evt;
      overflow     <= fall_evt && sat;
    end
  end

  // Loaded with 1 on the rising cycle so the final count equals the input high time.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (rise_evt) begin
      cnt <= CNT_ONE;
      sat <= 1'b0;
    end else if (active && !fall_evt) begin
      if (cnt == CNT_MAX) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // A soft clear abandons the pulse in flight but keeps the last reported width.
  always_ff @(posedge clk) begin
    if (rst) begin
      width <= '0;
    end else if (fall_evt && !clear) begin
      width <= cnt;
    end
  end

endmodule

// File: tb/tb_pulse_edge_encoder.sv
// Directed table and sequence checks of pulse_edge_encoder across three parameter sets.
`timescale 1ns/1ps
module tb_pulse_edge_encoder;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic pulse_in;

  always #5 clk = ~clk;

  logic        r0, f0, a0, wv0, o0;
  logic [31:0] w0;
  logic        r1, f1, a1, wv1, o1;
  logic [31:0] w1;
  logic        r2, f2, a2, wv2, o2;
  logic [3:0]  w2;

  pulse_edge_encoder u0 (
    .clk(clk), .rst(rst), .clear(clear), .pulse_in(pulse_in),
    .rising_edge(r0), .falling_edge(f0), .active(a0),
    .width(w0), .width_valid(wv0), .overflow(o0)
  );

  pulse_edge_encoder #(.MIN_WIDTH(4)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .pulse_in(pulse_in),
    .rising_edge(r1), .falling_edge(f1), .active(a1),
    .width(w1), .width_valid(wv1), .overflow(o1)
  );

  pulse_edge_encoder #(.CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .pulse_in(pulse_in),
    .rising_edge(r2), .falling_edge(f2), .active(a2),
    .width(w2), .width_valid(wv2), .overflow(o2)
  );

  // Flag order: {rising_edge, falling_edge, active, width_valid, overflow}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] RISE = 5'b10100;
  localparam logic [4:0] ACT  = 5'b00100;
  localparam logic [4:0] FALL = 5'b01010;

  typedef struct {
    logic        pin;
    logic        clr;
    logic [4:0]  flags;
    logic [31:0] w;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(input logic pin, input logic clr, input logic [4:0] flags,
                             input logic [31:0] w);
    vec_t t;
    t.pin = pin; t.clr = clr; t.flags = flags; t.w = w;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; pulse_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    logic hist[$];
    logic recon;
    logic exp_lvl;

    // Reset state, with pulse_in already high across reset release
    rst = 1'b1; clear = 1'b0; pulse_in = 1'b1;
    tick(); tick();
    check("reset_flags", 64'({r0, f0, a0, wv0, o0}), 64'(0));
    check("reset_width", 64'(w0), 64'(0));
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rise_after_reset c%0d", c), 64'(r0), 64'(c == 3));
    end
    pulse_in = 1'b0;
    repeat (6) tick();

    // 10-cycle pulse, clear mid-pulse, then a clean 6-cycle pulse
    repeat (3) tv.push_back(v(1, 0, NONE, 0));
    tv.push_back(v(1, 0, RISE, 0));
    repeat (6) tv.push_back(v(1, 0, ACT, 0));
    repeat (3) tv.push_back(v(0, 0, ACT, 0));
    tv.push_back(v(0, 0, FALL, 10));
    repeat (2) tv.push_back(v(0, 0, NONE, 10));

    repeat (3) tv.push_back(v(1, 0, NONE, 10));
    tv.push_back(v(1, 0, RISE, 10));
    tv.push_back(v(1, 0, ACT, 10));
    tv.push_back(v(1, 1, NONE, 10));
    repeat (3) tv.push_back(v(1, 0, NONE, 10));
    tv.push_back(v(1, 0, RISE, 10));
    repeat (3) tv.push_back(v(0, 0, ACT, 10));
    tv.push_back(v(0, 0, FALL, 4));
    repeat (2) tv.push_back(v(0, 0, NONE, 4));

    repeat (3) tv.push_back(v(1, 0, NONE, 4));
    tv.push_back(v(1, 0, RISE, 4));
    repeat (2) tv.push_back(v(1, 0, ACT, 4));
    repeat (3) tv.push_back(v(0, 0, ACT, 4));
    tv.push_back(v(0, 0, FALL, 6));
    repeat (2) tv.push_back(v(0, 0, NONE, 6));

    do_reset();
    foreach (tv[i]) begin
      pulse_in = tv[i].pin;
      clear    = tv[i].clr;
      tick();
      check($sformatf("table[%0d]", i), 64'({w0, r0, f0, a0, wv0, o0}),
            64'({tv[i].w, tv[i].flags}));
    end
    clear = 1'b0;

    // MIN_WIDTH=4: a 3-cycle excursion is swallowed
    do_reset();
    for (int c = 0; c < 14; c++) begin
      pulse_in = (c < 3);
      tick();
      check($sformatf("mw_short c%0d", c), 64'({r1, f1, a1, wv1}), 64'(0));
    end
    // MIN_WIDTH=4: a 4-cycle pulse is encoded
    for (int c = 0; c < 14; c++) begin
      pulse_in = (c < 4);
      tick();
      check($sformatf("mw_strobes c%0d", c), 64'({r1, f1}), 64'({c == 6, c == 10}));
      if (c == 10) check("mw_width", 64'({wv1, w1}), 64'({1'b1, 32'd4}));
    end

    // CNT_W=4 saturation on a 20-cycle pulse; full-width instance sees 20
    do_reset();
    for (int c = 0; c < 26; c++) begin
      pulse_in = (c < 20);
      tick();
      check($sformatf("sat_ovf c%0d", c), 64'({wv2, o2}), 64'({c == 23, c == 23}));
      if (c == 23) begin
        check("sat_width", 64'(w2), 64'(15));
        check("wide_width", 64'({wv0, o0, w0}), 64'({1'b1, 1'b0, 32'd20}));
      end
    end

    // CNT_W=4 with exactly 15 cycles fits without overflow
    do_reset();
    for (int c = 0; c < 21; c++) begin
      pulse_in = (c < 15);
      tick();
      if (c == 18) check("fit_width", 64'({wv2, o2, w2}), 64'({1'b1, 1'b0, 4'd15}));
    end

    // Random pulse train rebuilt from strobes must match the input delayed by 3
    do_reset();
    for (int p = 0; p < 12; p++) begin
      repeat ($urandom_range(50, 1)) hist.push_back(1'b0);
      repeat ($urandom_range(50, 1)) hist.push_back(1'b1);
    end
    repeat (10) hist.push_back(1'b0);
    recon = 1'b0;
    for (int c = 0; c < hist.size(); c++) begin
      pulse_in = hist[c];
      tick();
      if (r0) recon = 1'b1;
      else if (f0) recon = 1'b0;
      exp_lvl = (c >= 3) ? hist[c-3] : 1'b0;
      check($sformatf("recon c%0d", c), 64'({r0 & f0, recon}), 64'({1'b0, exp_lvl}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
